// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared writeback types for the register-file writeback arbiter: the holding
// entry layout, the x0 index and the producer numbering used by the grant vector.
package rv_wb_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_WB_SRC = 2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic            vld;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // Bit positions of each producer in the grant vector.
  typedef enum logic [0:0] {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  // True when a live entry targets idx; x0 is never reported.
  function automatic logic rd_match(input wb_entry_t e, input logic [4:0] idx);
    return e.vld && (e.rd == idx) && (idx != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: ALU/LSU result handshakes, register-file write port and bypass lookup.
// The arbiter takes the master side; producers, register file and operand read use slave.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);

  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;

  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;

  logic            wr_en;
  logic [4:0]      wr_idx;
  logic [XLEN-1:0] wr_data;

  logic [4:0]      byp_idx;
  logic            byp_hit;
  logic [XLEN-1:0] byp_data;

  modport master (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  byp_idx,
    output alu_ready, lsu_ready,
    output wr_en, wr_idx, wr_data,
    output byp_hit, byp_data
  );

  modport slave (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output byp_idx,
    input  alu_ready, lsu_ready,
    input  wr_en, wr_idx, wr_data,
    input  byp_hit, byp_data
  );

endinterface

// File: rtl/regfile_wb_arbiter_hold_slot.sv
// One-entry holding register for a single writeback producer. It accepts a new
// result whenever empty or when its current entry is being granted this cycle.
module wb_hold_slot
  import rv_wb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_data,
  input  logic            grant,
  output wb_entry_t       entry
);

  wb_entry_t entry_q;

  // Ready looks only at occupancy and grant, never at in_valid.
  assign in_ready = !entry_q.vld || grant;
  assign entry    = entry_q;

  // NOTE: only the valid bit is reset; rd/data are qualified by vld, so leaving
  // the payload unreset saves reset fan-out without exposing stale values.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q.vld <= 1'b0;
    end else if (in_valid && in_ready) begin
      // Writes to x0 complete the handshake but leave the slot empty.
      entry_q.vld  <= (in_rd != REG_ZERO);
      entry_q.rd   <= in_rd;
      entry_q.data <= in_data;
    end else if (grant) begin
      entry_q.vld <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: buffers ALU and LSU results, commits one per cycle to the
// register file, and bypasses uncommitted results. WB_STATS_EN adds commit/stall counters.
module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_arbiter_if.master  bus
`ifdef WB_STATS_EN
  ,
  output logic [31:0]           stat_commits,
  output logic [31:0]           stat_stall
`endif
);

  import rv_wb_pkg::*;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  wb_entry_t             ent [NUM_WB_SRC];
  logic [NUM_WB_SRC-1:0] grant;
  logic [3:0]            starve_cnt;

  logic                  wr_en_q;
  logic [4:0]            wr_idx_q;
  logic [XLEN-1:0]       wr_data_q;

  wb_hold_slot u_alu_slot (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.alu_valid),
    .in_ready (bus.alu_ready),
    .in_rd    (bus.alu_rd),
    .in_data  (bus.alu_data),
    .grant    (grant[SRC_ALU]),
    .entry    (ent[SRC_ALU])
  );

  wb_hold_slot u_lsu_slot (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.lsu_valid),
    .in_ready (bus.lsu_ready),
    .in_rd    (bus.lsu_rd),
    .in_data  (bus.lsu_data),
    .grant    (grant[SRC_LSU]),
    .entry    (ent[SRC_LSU])
  );

  // LSU has priority until the ALU has watched STARVE_MAX LSU grants go by.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant = '0;
    if (ent[SRC_LSU].vld && !(ent[SRC_ALU].vld && starve_cnt == STARVE_LIM)) begin
      grant[SRC_LSU] = 1'b1;
    end else if (ent[SRC_ALU].vld) begin
      grant[SRC_ALU] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!ent[SRC_ALU].vld || grant[SRC_ALU]) begin
      starve_cnt <= '0;
    end else if (grant[SRC_LSU] && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Output register: wr_en pulses once per commit; index/data hold between commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= |grant;
      if (grant[SRC_LSU]) begin
        wr_idx_q  <= ent[SRC_LSU].rd;
        wr_data_q <= ent[SRC_LSU].data;
      end else if (grant[SRC_ALU]) begin
        wr_idx_q  <= ent[SRC_ALU].rd;
        wr_data_q <= ent[SRC_ALU].data;
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_idx  = wr_idx_q;
  assign bus.wr_data = wr_data_q;

  // Upstream allows only one in-flight write per rd, so an OR of masked sources suffices.
  wb_entry_t out_ent;
  logic      hit_alu, hit_lsu, hit_out;

  assign out_ent = '{vld: wr_en_q, rd: wr_idx_q, data: wr_data_q};
  assign hit_alu = rd_match(ent[SRC_ALU], bus.byp_idx);
  assign hit_lsu = rd_match(ent[SRC_LSU], bus.byp_idx);
  assign hit_out = rd_match(out_ent, bus.byp_idx);

  assign bus.byp_hit  = hit_alu || hit_lsu || hit_out;
  assign bus.byp_data = ({XLEN{hit_alu}} & ent[SRC_ALU].data)
                      | ({XLEN{hit_lsu}} & ent[SRC_LSU].data)
                      | ({XLEN{hit_out}} & wr_data_q);

`ifdef WB_STATS_EN
  logic stall_now;

  assign stall_now = (bus.alu_valid && !bus.alu_ready) || (bus.lsu_valid && !bus.lsu_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_commits <= '0;
      stat_stall   <= '0;
    end else begin
      if (wr_en_q)   stat_commits <= stat_commits + 32'd1;
      if (stall_now) stat_stall   <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a source-level model checked every cycle,
// plus literal expectations for latency, x0, fairness, back-pressure and reset.
module tb_regfile_wb_arbiter;

  localparam int SM = 4;
  localparam int XL = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XL)) bus ();

`ifdef WB_STATS_EN
  logic [31:0] stat_commits, stat_stall;
`endif

  regfile_wb_arbiter #(.STARVE_MAX(SM), .XLEN(XL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
`ifdef WB_STATS_EN
    ,
    .stat_commits (stat_commits),
    .stat_stall   (stat_stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        v;
    bit [4:0]  rd;
    bit [31:0] d;
  } ent_t;

  ent_t      m_alu, m_lsu;
  bit        m_wr_en;
  bit [4:0]  m_wr_idx;
  bit [31:0] m_wr_data;
  int        streak;
  bit        model_ok = 1'b0;

  function automatic bit pick_lsu();
    return m_lsu.v && !(m_alu.v && streak == SM);
  endfunction

  function automatic bit pick_alu();
    return m_alu.v && !pick_lsu();
  endfunction

  function automatic int byp_matches(input bit [4:0] idx, output bit [31:0] d);
    int n = 0;
    d = '0;
    if (idx != 5'd0) begin
      if (m_alu.v && m_alu.rd == idx) begin n++; d = m_alu.d; end
      if (m_lsu.v && m_lsu.rd == idx) begin n++; d = m_lsu.d; end
      if (m_wr_en && m_wr_idx == idx) begin n++; d = m_wr_data; end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_alu     = '{0, 0, 0};
      m_lsu     = '{0, 0, 0};
      m_wr_en   = 0;
      m_wr_idx  = 0;
      m_wr_data = 0;
      streak    = 0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      bit ga, gl, ar, lr;
      gl = pick_lsu();
      ga = pick_alu();
      ar = !m_alu.v || ga;
      lr = !m_lsu.v || gl;
      m_wr_en = ga || gl;
      if (gl)      begin m_wr_idx = m_lsu.rd; m_wr_data = m_lsu.d; end
      else if (ga) begin m_wr_idx = m_alu.rd; m_wr_data = m_alu.d; end
      if (!m_alu.v || ga) streak = 0;
      else if (gl && streak < SM) streak++;
      if (bus.alu_valid && ar) m_alu = '{bus.alu_rd != 0, bus.alu_rd, bus.alu_data};
      else if (ga)             m_alu.v = 0;
      if (bus.lsu_valid && lr) m_lsu = '{bus.lsu_rd != 0, bus.lsu_rd, bus.lsu_data};
      else if (gl)             m_lsu.v = 0;
    end
  end

  // ---------------- per-cycle compare + commit log ----------------
  logic [36:0] commit_q [$];

  always @(negedge clk) begin
    if (model_ok) begin
      int        n;
      bit [31:0] bd;
      check("alu_ready", bus.alu_ready, !m_alu.v || pick_alu());
      check("lsu_ready", bus.lsu_ready, !m_lsu.v || pick_lsu());
      check("wr_en",     bus.wr_en,     m_wr_en);
      check("wr_idx",    bus.wr_idx,    m_wr_idx);
      check("wr_data",   bus.wr_data,   m_wr_data);
      n = byp_matches(bus.byp_idx, bd);
      if (n <= 1) begin
        check("byp_hit",  bus.byp_hit,  n == 1);
        check("byp_data", bus.byp_data, bd);
      end
      if (bus.wr_en) commit_q.push_back({bus.wr_idx, bus.wr_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [4:0] exp_seq [10];
    bit         fired;
    int         stalls, cnt;

    exp_seq = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd1, 5'd1, 5'd1, 5'd1, 5'd2};

    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.byp_idx   = 0;

    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    check("rst_wr_en",  bus.wr_en,     0);
    check("rst_wr_idx", bus.wr_idx,    0);
    check("rst_wr_dat", bus.wr_data,   0);
    check("rst_alu_rdy", bus.alu_ready, 1);
    check("rst_lsu_rdy", bus.lsu_ready, 1);

    // ALU alone: one-cycle latency to wr_en, bypass visible until commit ends.
    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF; bus.byp_idx = 5;
    step();
    bus.alu_valid = 0;
    #1;
    check("alu1_c0_wr_en", bus.wr_en, 0);
    check("alu1_c0_hit",   bus.byp_hit, 1);
    check("alu1_c0_bdat",  bus.byp_data, 32'hDEADBEEF);
    step(); #1;
    check("alu1_c1_wr_en", bus.wr_en, 1);
    check("alu1_c1_idx",   bus.wr_idx, 5);
    check("alu1_c1_data",  bus.wr_data, 32'hDEADBEEF);
    check("alu1_c1_hit",   bus.byp_hit, 1);
    step(); #1;
    check("alu1_c2_wr_en", bus.wr_en, 0);
    check("alu1_c2_hit",   bus.byp_hit, 0);
    check("alu1_c2_bdat",  bus.byp_data, 0);

    // rd=0: accepted, never written, never bypassed.
    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'h1234; bus.byp_idx = 0;
    #1 check("x0_ready", bus.alu_ready, 1);
    step();
    bus.alu_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("x0_wr_en", bus.wr_en, 0);
      check("x0_hit",   bus.byp_hit, 0);
      step();
    end

    // Fairness: both producers valid every cycle.
    commit_q.delete();
    bus.byp_idx   = 9;
    bus.lsu_valid = 1; bus.lsu_rd = 1; bus.lsu_data = 32'h100;
    bus.alu_valid = 1; bus.alu_rd = 2; bus.alu_data = 32'h200;
    repeat (12) step();
    bus.lsu_valid = 0; bus.alu_valid = 0;
    repeat (4) step();
    check("fair_count_ge10", commit_q.size() >= 10, 1);
    for (int i = 0; i < 10 && i < commit_q.size(); i++)
      check($sformatf("fair_seq%0d", i), commit_q[i][36:32], exp_seq[i]);

    // Back-pressure: held ALU result waits for its grant and commits once.
    commit_q.delete();
    bus.lsu_valid = 1; bus.lsu_rd = 1; bus.lsu_data = 32'h55;
    bus.alu_valid = 1; bus.alu_rd = 6; bus.alu_data = 32'h1111;
    step();
    bus.alu_rd = 7; bus.alu_data = 32'hA5A5A5A5;
    fired = 0; stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      fired = bus.alu_valid && bus.alu_ready;
      if (!bus.alu_ready) stalls++;
      step();
      if (fired) break;
    end
    bus.alu_valid = 0;
    check("bp_handshake", fired, 1);
    check("bp_stalls", stalls, 4);
    repeat (12) step();
    bus.lsu_valid = 0;
    repeat (4) step();
    cnt = 0;
    foreach (commit_q[i]) if (commit_q[i] == {5'd7, 32'hA5A5A5A5}) cnt++;
    check("bp_a5_once", cnt, 1);

    // Reset mid-flight discards both holding entries.
    bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'h33;
    bus.lsu_valid = 1; bus.lsu_rd = 4; bus.lsu_data = 32'h44;
    step();
    bus.alu_valid = 0; bus.lsu_valid = 0;
    reset = 1; bus.byp_idx = 3;
    step();
    reset = 0;
    commit_q.delete();
    #1;
    check("rst2_hit3",    bus.byp_hit, 0);
    check("rst2_alu_rdy", bus.alu_ready, 1);
    check("rst2_lsu_rdy", bus.lsu_ready, 1);
    check("rst2_wr_en",   bus.wr_en, 0);
    bus.byp_idx = 4;
    #1 check("rst2_hit4", bus.byp_hit, 0);
    repeat (4) step();
    cnt = 0;
    foreach (commit_q[i]) if (commit_q[i][36:32] == 5'd3 || commit_q[i][36:32] == 5'd4) cnt++;
    check("rst2_no_commit", cnt, 0);

`ifdef WB_STATS_EN
    reset = 1;
    step();
    reset = 0;
    for (int i = 1; i <= 10; i++) begin
      bus.alu_valid = 1; bus.alu_rd = 5'(i); bus.alu_data = 32'(i * 3);
      step();
    end
    bus.alu_valid = 0;
    repeat (3) step();
    check("stat_commits", stat_commits, 10);
    check("stat_stall",   stat_stall, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
